pl_accessory_port: RTL and testbench

Accessory-side endpoint for the G-15 CPU's PL19/PL20 accessory connectors: it is the device the CPU talks to, not the CPU itself. It deserializes 29-bit words shifted out by the CPU on PL20 into a host-side word FIFO. It serializes host-supplied words onto PL19 when the CPU requests input. It sits between the CPU's accessory interface and a parallel word-oriented peripheral model or host bridge.

---
 rtl/pl_accessory_port_pkg.sv | 20 ++
 rtl/pl_accessory_port_if.sv | 23 ++
 rtl/pl_accessory_port_fifo.sv | 52 +++++
 rtl/pl_accessory_port.sv | 155 +++++++++++++++
 tb/tb_pl_accessory_port.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pl_accessory_port_pkg.sv
// Shared types and constants for the G-15 PL19/PL20 accessory endpoint.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package g15_acc_pkg;

    // G-15 word width; bit 0 is the sign bit and travels first on the line.
    localparam int WORD_W   = 29;
    localparam int BITCNT_W = $clog2(WORD_W);

    typedef logic [WORD_W-1:0] acc_word_t;

    // Input-path (host -> CPU) transfer states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_WORD  = 2'd1,
        SHIFTING   = 2'd2,
        WAIT_WRITE = 2'd3
    } acc_in_state_e;

endpackage

// File: rtl/pl_accessory_port_if.sv
// Host-side word handshakes of the accessory endpoint (output words to the host, input words from it).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both directions; master = accessory endpoint, slave = host/peripheral model.
interface pl_accessory_port_if;
    import g15_acc_pkg::*;

    acc_word_t out_word;   // head word captured from PL20
    logic      out_valid;
    logic      out_ready;
    acc_word_t in_word;    // next word to serialize onto PL19
    logic      in_valid;
    logic      in_ready;

    modport master (
        output out_word, out_valid, in_ready,
        input  out_ready, in_word, in_valid
    );

    modport slave (
        input  out_word, out_valid, in_ready,
        output out_ready, in_word, in_valid
    );
endinterface

// File: rtl/pl_accessory_port_fifo.sv
// Small synchronous word FIFO for the PL20 output path; head is 0 while empty.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push is accepted when not full, or when full and popping in the same cycle.
// Ports: clk, rst_n, push/push_word, pop, full, empty, head.
module acc_word_fifo
    import g15_acc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  acc_word_t push_word,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output acc_word_t head
);
    localparam int AW = $clog2(DEPTH);

    acc_word_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a push on a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end
endmodule

// File: rtl/pl_accessory_port.sv
// G-15 accessory endpoint: deserializes PL20 words to the host, serializes host words onto PL19.
// Latency: 29th PL20 shift -> out_valid next cycle; in handshake -> PL19_READY_IN/bit0 next cycle.
// Backpressure: PL20_READY_OUT = output store not full (words arriving when full are dropped, ovf_err); in_ready only in WAIT_WORD.
// Ports: CLOCK, rst_n, PL20_* (CPU output), PL19_* (CPU input), host (word handshakes), ovf_err.
// Option: G15_ACC_OUT_FIFO_EN selects a FIFO_DEPTH-entry output FIFO; otherwise a single holding register.
module pl_accessory_port
    import g15_acc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic CLOCK,
    input  logic rst_n,
    input  logic PL20_OUTPUT,
    input  logic PL20_OUTPUT_SHIFT,
    output logic PL20_READY_OUT,
    input  logic PL19_START_INPUT,
    input  logic PL19_STOP_INPUT,
    input  logic PL19_SHIFT_CMD,
    input  logic PL19_SHIFT_CMD_M20,
    input  logic PL19_WRITE_PULSE,
    output logic PL19_INPUT,
    output logic PL19_READY_IN,
    pl_accessory_port_if.master host,
    output logic ovf_err
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    // ---------------- Output path (CPU -> host) ----------------
    // Only WORD_W-1 bits are held; the final bit joins straight from the pin.
    logic [WORD_W-2:0]   out_sreg;
    logic [BITCNT_W-1:0] out_cnt;
    logic                word_done;
    acc_word_t           word_asm;
    logic                pop;
    logic                full;

    assign word_done = PL20_OUTPUT_SHIFT && (out_cnt == BITCNT_W'(WORD_W - 1));
    assign word_asm  = {PL20_OUTPUT, out_sreg};
    assign pop       = host.out_valid && host.out_ready;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            out_sreg <= '0;
            out_cnt  <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (PL20_OUTPUT_SHIFT) begin
                out_sreg <= {PL20_OUTPUT, out_sreg[WORD_W-2:1]};
                out_cnt  <= word_done ? '0 : out_cnt + 1'b1;
            end
            if (word_done && full && !pop) ovf_err <= 1'b1;
        end
    end

`ifdef G15_ACC_OUT_FIFO_EN
    logic      empty;
    acc_word_t fifo_head;

    acc_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLOCK),
        .rst_n     (rst_n),
        .push      (word_done),
        .push_word (word_asm),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (fifo_head)
    );

    assign host.out_word  = fifo_head;
    assign host.out_valid = !empty;
`else
    acc_word_t hold_word;
    logic      hold_vld;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            hold_word <= '0;
            hold_vld  <= 1'b0;
        end else if (word_done && (!hold_vld || pop)) begin
            hold_word <= word_asm;
            hold_vld  <= 1'b1;
        end else if (pop) begin
            hold_vld  <= 1'b0;
        end
    end

    assign full           = hold_vld;
    assign host.out_word  = hold_word;
    assign host.out_valid = hold_vld;
`endif

    assign PL20_READY_OUT = !full;

    // ---------------- Input path (host -> CPU) ----------------
    acc_in_state_e       state;
    acc_in_state_e       state_nxt;
    acc_word_t           in_sreg;
    logic [BITCNT_W-1:0] in_cnt;
    logic                in_shift;
    logic                in_rdy;

    assign in_shift      = PL19_SHIFT_CMD || PL19_SHIFT_CMD_M20;
    assign host.in_ready = in_rdy;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Outputs depend on state and registered data only, never on the strobes.
    always_comb begin
        state_nxt     = state;
        in_rdy        = 1'b0;
        PL19_READY_IN = 1'b0;
        PL19_INPUT    = 1'b0;
        case (state)
            WAIT_WORD: in_rdy = 1'b1;
            SHIFTING: begin
                PL19_READY_IN = 1'b1;
                PL19_INPUT    = in_sreg[0];
            end
            default: ;
        endcase
        // STOP outranks every other strobe in the same cycle.
        if (PL19_STOP_INPUT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:       if (PL19_START_INPUT) state_nxt = WAIT_WORD;
                WAIT_WORD:  if (host.in_valid)    state_nxt = SHIFTING;
                SHIFTING:   if (in_shift && in_cnt == BITCNT_W'(WORD_W - 1)) state_nxt = WAIT_WRITE;
                WAIT_WRITE: if (PL19_WRITE_PULSE) state_nxt = WAIT_WORD;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            in_sreg <= '0;
            in_cnt  <= '0;
        end else if (PL19_STOP_INPUT) begin
            in_cnt  <= '0;
        end else if (state == WAIT_WORD && host.in_valid) begin
            in_sreg <= host.in_word;
            in_cnt  <= '0;
        end else if (state == SHIFTING && in_shift) begin
            in_sreg <= in_sreg >> 1;
            in_cnt  <= in_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pl_accessory_port.sv
// Directed bench for pl_accessory_port: both serial paths, overflow, aborts and mid-transfer reset.
// Latency: n/a (testbench).
// Backpressure: host side driven directly from tasks.
module tb_pl_accessory_port;
    import g15_acc_pkg::*;

`ifdef G15_ACC_OUT_FIFO_EN
    localparam int OUT_CAP = 4;
`else
    localparam int OUT_CAP = 1;
`endif

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic rst_n;
    logic PL20_OUTPUT, PL20_OUTPUT_SHIFT, PL20_READY_OUT;
    logic PL19_START_INPUT, PL19_STOP_INPUT, PL19_SHIFT_CMD, PL19_SHIFT_CMD_M20, PL19_WRITE_PULSE;
    logic PL19_INPUT, PL19_READY_IN, ovf_err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    pl_accessory_port_if host();

    pl_accessory_port #(.FIFO_DEPTH(4)) dut (
        .CLOCK              (CLOCK),
        .rst_n              (rst_n),
        .PL20_OUTPUT        (PL20_OUTPUT),
        .PL20_OUTPUT_SHIFT  (PL20_OUTPUT_SHIFT),
        .PL20_READY_OUT     (PL20_READY_OUT),
        .PL19_START_INPUT   (PL19_START_INPUT),
        .PL19_STOP_INPUT    (PL19_STOP_INPUT),
        .PL19_SHIFT_CMD     (PL19_SHIFT_CMD),
        .PL19_SHIFT_CMD_M20 (PL19_SHIFT_CMD_M20),
        .PL19_WRITE_PULSE   (PL19_WRITE_PULSE),
        .PL19_INPUT         (PL19_INPUT),
        .PL19_READY_IN      (PL19_READY_IN),
        .host               (host),
        .ovf_err            (ovf_err)
    );

    task automatic pulse_start();
        PL19_START_INPUT = 1'b1; @(negedge CLOCK); PL19_START_INPUT = 1'b0;
    endtask

    task automatic pulse_stop();
        PL19_STOP_INPUT = 1'b1; @(negedge CLOCK); PL19_STOP_INPUT = 1'b0;
    endtask

    task automatic pulse_write();
        PL19_WRITE_PULSE = 1'b1; @(negedge CLOCK); PL19_WRITE_PULSE = 1'b0;
    endtask

    task automatic pop_word();
        host.out_ready = 1'b1; @(negedge CLOCK); host.out_ready = 1'b0;
    endtask

    // Shifts nbits of w onto PL20 LSB first; optionally pops during the last strobe.
    task automatic send_out_word(input acc_word_t w, input int nbits, input logic pop_last);
        for (int i = 0; i < nbits; i++) begin
            PL20_OUTPUT       = w[i];
            PL20_OUTPUT_SHIFT = 1'b1;
            if (i == nbits - 1) host.out_ready = pop_last;
            @(negedge CLOCK);
        end
        PL20_OUTPUT_SHIFT = 1'b0;
        PL20_OUTPUT       = 1'b0;
        host.out_ready    = 1'b0;
    endtask

    // From WAIT_WORD: hand over w, then strobe 29 times recording PL19_INPUT before each strobe.
    task automatic shift_in_word(input acc_word_t w, input logic alt, output acc_word_t got, output logic rdy_all);
        acc_word_t g;
        logic      r;
        g = '0;
        r = 1'b1;
        host.in_word  = w;
        host.in_valid = 1'b1;
        @(negedge CLOCK);
        host.in_valid = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            g[i] = PL19_INPUT;
            r    = r & PL19_READY_IN;
            if (alt && i[0]) PL19_SHIFT_CMD_M20 = 1'b1;
            else             PL19_SHIFT_CMD     = 1'b1;
            @(negedge CLOCK);
            PL19_SHIFT_CMD     = 1'b0;
            PL19_SHIFT_CMD_M20 = 1'b0;
        end
        got     = g;
        rdy_all = r;
    endtask

    task automatic test_reset();
        check_cnt++; if (PL20_READY_OUT !== 1'b1) $display("FAIL rst_ready_out got %b want 1", PL20_READY_OUT); else pass_cnt++;
        check_cnt++; if (host.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", host.out_valid); else pass_cnt++;
        check_cnt++; if (host.out_word !== 29'h0) $display("FAIL rst_out_word got %h want 0", host.out_word); else pass_cnt++;
        check_cnt++; if (host.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", host.in_ready); else pass_cnt++;
        check_cnt++; if (PL19_READY_IN !== 1'b0) $display("FAIL rst_ready_in got %b want 0", PL19_READY_IN); else pass_cnt++;
        check_cnt++; if (PL19_INPUT !== 1'b0) $display("FAIL rst_pl19_input got %b want 0", PL19_INPUT); else pass_cnt++;
        check_cnt++; if (ovf_err !== 1'b0) $display("FAIL rst_ovf got %b want 0", ovf_err); else pass_cnt++;
    endtask

    task automatic test_out_word();
        logic exp_rdy;
        exp_rdy = (OUT_CAP > 1);
        send_out_word(29'h0ABCDEF1, WORD_W, 1'b0);
        check_cnt++; if (host.out_valid !== 1'b1) $display("FAIL out_valid got %b want 1", host.out_valid); else pass_cnt++;
        check_cnt++; if (host.out_word !== 29'h0ABCDEF1) $display("FAIL out_word got %h want 0abcdef1", host.out_word); else pass_cnt++;
        check_cnt++; if (PL20_READY_OUT !== exp_rdy) $display("FAIL out_ready_out got %b want %b", PL20_READY_OUT, exp_rdy); else pass_cnt++;
        pop_word();
        check_cnt++; if (host.out_valid !== 1'b0) $display("FAIL out_pop_valid got %b want 0", host.out_valid); else pass_cnt++;
        check_cnt++; if (PL20_READY_OUT !== 1'b1) $display("FAIL out_pop_ready got %b want 1", PL20_READY_OUT); else pass_cnt++;
    endtask

    task automatic test_in_word();
        acc_word_t got;
        logic      rdy_all;
        pulse_start();
        check_cnt++; if (host.in_ready !== 1'b1) $display("FAIL in_start_ready got %b want 1", host.in_ready); else pass_cnt++;
        shift_in_word(29'h1000001, 1'b0, got, rdy_all);
        check_cnt++; if (got !== 29'h1000001) $display("FAIL in_stream got %h want 1000001", got); else pass_cnt++;
        check_cnt++; if (rdy_all !== 1'b1) $display("FAIL in_ready_in_during got %b want 1", rdy_all); else pass_cnt++;
        check_cnt++; if (PL19_READY_IN !== 1'b0) $display("FAIL in_ready_in_after got %b want 0", PL19_READY_IN); else pass_cnt++;
        check_cnt++; if (PL19_INPUT !== 1'b0) $display("FAIL in_bit_after got %b want 0", PL19_INPUT); else pass_cnt++;
        check_cnt++; if (host.in_ready !== 1'b0) $display("FAIL in_wait_write_ready got %b want 0", host.in_ready); else pass_cnt++;
        pulse_write();
        check_cnt++; if (host.in_ready !== 1'b1) $display("FAIL in_write_ready got %b want 1", host.in_ready); else pass_cnt++;
    endtask

    task automatic test_m20();
        acc_word_t got;
        logic      rdy_all;
        shift_in_word(29'h1A5C3E7, 1'b1, got, rdy_all);
        check_cnt++; if (got !== 29'h1A5C3E7) $display("FAIL m20_stream got %h want 1a5c3e7", got); else pass_cnt++;
        check_cnt++; if (PL19_READY_IN !== 1'b0) $display("FAIL m20_ready_in got %b want 0", PL19_READY_IN); else pass_cnt++;
        pulse_write();
    endtask

    task automatic test_abort();
        host.in_word  = 29'h12345AB;
        host.in_valid = 1'b1;
        @(negedge CLOCK);
        host.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            PL19_SHIFT_CMD = 1'b1; @(negedge CLOCK); PL19_SHIFT_CMD = 1'b0;
        end
        pulse_stop();
        check_cnt++; if (PL19_READY_IN !== 1'b0) $display("FAIL abort_ready_in got %b want 0", PL19_READY_IN); else pass_cnt++;
        check_cnt++; if (host.in_ready !== 1'b0) $display("FAIL abort_in_ready got %b want 0", host.in_ready); else pass_cnt++;
        pulse_write();
        check_cnt++; if (host.in_ready !== 1'b0) $display("FAIL idle_write_ignored got %b want 0", host.in_ready); else pass_cnt++;
        pulse_start();
        host.in_word  = 29'h0000002;
        host.in_valid = 1'b1;
        @(negedge CLOCK);
        host.in_valid = 1'b0;
        check_cnt++; if (PL19_INPUT !== 1'b0 || PL19_READY_IN !== 1'b1) $display("FAIL coll_loaded got %b%b want 01", PL19_INPUT, PL19_READY_IN); else pass_cnt++;
        PL19_STOP_INPUT = 1'b1;
        PL19_SHIFT_CMD  = 1'b1;
        @(negedge CLOCK);
        PL19_STOP_INPUT = 1'b0;
        PL19_SHIFT_CMD  = 1'b0;
        check_cnt++; if (PL19_READY_IN !== 1'b0 || PL19_INPUT !== 1'b0) $display("FAIL coll_stop_shift got %b%b want 00", PL19_READY_IN, PL19_INPUT); else pass_cnt++;
        pulse_start();
    endtask

    task automatic test_push_pop_full();
        acc_word_t exp_q[$];
        for (int k = 0; k < OUT_CAP; k++) begin
            send_out_word(acc_word_t'(29'h0100000 + k), WORD_W, 1'b0);
            exp_q.push_back(acc_word_t'(29'h0100000 + k));
        end
        check_cnt++; if (PL20_READY_OUT !== 1'b0) $display("FAIL pp_full_ready got %b want 0", PL20_READY_OUT); else pass_cnt++;
        send_out_word(29'h1555555, WORD_W, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(29'h1555555);
        check_cnt++; if (ovf_err !== 1'b0) $display("FAIL pp_no_ovf got %b want 0", ovf_err); else pass_cnt++;
        for (int k = 0; k < OUT_CAP; k++) begin
            check_cnt++; if (host.out_word !== exp_q[k] || host.out_valid !== 1'b1) $display("FAIL pp_drain%0d got %h/%b want %h/1", k, host.out_word, host.out_valid, exp_q[k]); else pass_cnt++;
            pop_word();
        end
        check_cnt++; if (host.out_valid !== 1'b0) $display("FAIL pp_empty got %b want 0", host.out_valid); else pass_cnt++;
    endtask

    task automatic test_overflow();
        acc_word_t w[5];
        logic      exp_rdy;
        w = '{29'h0000011, 29'h0000222, 29'h0003333, 29'h0044444, 29'h0555555};
        for (int k = 1; k <= OUT_CAP; k++) begin
            send_out_word(w[k-1], WORD_W, 1'b0);
            exp_rdy = (k < OUT_CAP);
            check_cnt++; if (PL20_READY_OUT !== exp_rdy || ovf_err !== 1'b0) $display("FAIL ovf_fill%0d got rdy %b ovf %b want %b 0", k, PL20_READY_OUT, ovf_err, exp_rdy); else pass_cnt++;
        end
        send_out_word(w[4], WORD_W, 1'b0);
        check_cnt++; if (ovf_err !== 1'b1) $display("FAIL ovf_set got %b want 1", ovf_err); else pass_cnt++;
        for (int k = 0; k < OUT_CAP; k++) begin
            check_cnt++; if (host.out_word !== w[k]) $display("FAIL ovf_drain%0d got %h want %h", k, host.out_word, w[k]); else pass_cnt++;
            pop_word();
        end
        check_cnt++; if (host.out_valid !== 1'b0 || ovf_err !== 1'b1) $display("FAIL ovf_after got %b%b want 01", host.out_valid, ovf_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        acc_word_t got;
        logic      rdy_all;
        send_out_word(29'h00C0FFE, WORD_W, 1'b0);
        host.in_word  = 29'h1FFFFFF;
        host.in_valid = 1'b1;
        @(negedge CLOCK);
        host.in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            PL20_OUTPUT        = i[0];
            PL20_OUTPUT_SHIFT  = 1'b1;
            PL19_SHIFT_CMD     = 1'b1;
            @(negedge CLOCK);
        end
        PL20_OUTPUT_SHIFT = 1'b0;
        PL19_SHIFT_CMD    = 1'b0;
        PL20_OUTPUT       = 1'b0;
        check_cnt++; if (PL19_INPUT !== 1'b1 || host.out_valid !== 1'b1) $display("FAIL mid_pre got %b%b want 11", PL19_INPUT, host.out_valid); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge CLOCK);
        rst_n = 1'b1;
        @(negedge CLOCK);
        send_out_word(29'h15A5A5A, WORD_W, 1'b0);
        check_cnt++; if (host.out_word !== 29'h15A5A5A || host.out_valid !== 1'b1) $display("FAIL mid_fresh_out got %h/%b want 15a5a5a/1", host.out_word, host.out_valid); else pass_cnt++;
        pulse_start();
        shift_in_word(29'h0F0F0F1, 1'b0, got, rdy_all);
        check_cnt++; if (got !== 29'h0F0F0F1 || rdy_all !== 1'b1) $display("FAIL mid_fresh_in got %h/%b want 0f0f0f1/1", got, rdy_all); else pass_cnt++;
    endtask

    initial begin
        rst_n              = 1'b1;
        PL20_OUTPUT        = 1'b0;
        PL20_OUTPUT_SHIFT  = 1'b0;
        PL19_START_INPUT   = 1'b0;
        PL19_STOP_INPUT    = 1'b0;
        PL19_SHIFT_CMD     = 1'b0;
        PL19_SHIFT_CMD_M20 = 1'b0;
        PL19_WRITE_PULSE   = 1'b0;
        host.out_ready     = 1'b0;
        host.in_word       = '0;
        host.in_valid      = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge CLOCK);
        test_reset();
        rst_n = 1'b1;
        @(negedge CLOCK);
        test_reset();
        test_out_word();
        test_in_word();
        test_m20();
        test_abort();
        test_push_pop_full();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
